// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect write path: controller states,
// response codes, slave count and a one-hot helper.
package axi_ic_pkg;

    localparam int NUM_SLAVES = 4;
    localparam int SLV_IDX_W  = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_DATA     = 3'd2,
        ST_RESP     = 3'd3,
        ST_ERR_DATA = 3'd4,
        ST_ERR_RESP = 3'd5
    } wr_state_e;

    // One-hot routing vector for a slave index.
    function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [SLV_IDX_W-1:0] idx);
        logic [NUM_SLAVES-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/wr_addr_decoder.sv
// Combinational address decoder: reports whether an address falls inside any
// slave window and, if so, the lowest-indexed matching slave.
module wr_addr_decoder
    import axi_ic_pkg::*;
#(
    parameter logic [NUM_SLAVES*32-1:0] SLV_BASE  = {32'h60000000, 32'h40000000, 32'h20000000, 32'h00000000},
    parameter logic [NUM_SLAVES*32-1:0] SLV_LIMIT = {32'h7FFFFFFF, 32'h5FFFFFFF, 32'h3FFFFFFF, 32'h1FFFFFFF}
) (
    input  logic [31:0]          addr,
    output logic                 hit,
    output logic [SLV_IDX_W-1:0] index
);

    logic [NUM_SLAVES-1:0] match;

    // Per-slave inclusive window test; bounds compared through 33-bit
    // differences so that a zero base never becomes a constant comparison.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_window
            logic [32:0] lo_diff;
            logic [32:0] hi_diff;
            assign lo_diff   = {1'b0, addr} - {1'b0, SLV_BASE[gi*32 +: 32]};
            assign hi_diff   = {1'b0, SLV_LIMIT[gi*32 +: 32]} - {1'b0, addr};
            assign match[gi] = ~lo_diff[32] & ~hi_diff[32];
        end
    endgenerate

    // Priority select: scanning downward lets the lowest index win overlaps.
    always_comb begin
        hit   = |match;
        index = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                index = SLV_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/write_arbiter_ctrl.sv
// Write-channel arbiter/controller for a 2-master, 4-slave AXI interconnect.
// Grants one master at a time by round-robin, routes AW/W/B to the decoded
// slave, and answers unmapped addresses with an internal DECERR responder.
module write_arbiter_ctrl
    import axi_ic_pkg::*;
#(
    parameter logic [NUM_SLAVES*32-1:0] SLV_BASE  = {32'h60000000, 32'h40000000, 32'h20000000, 32'h00000000},
    parameter logic [NUM_SLAVES*32-1:0] SLV_LIMIT = {32'h7FFFFFFF, 32'h5FFFFFFF, 32'h3FFFFFFF, 32'h1FFFFFFF}
) (
    input  logic                  clkk,
    input  logic                  resett,
    input  logic                  M0_AWVALID,
    input  logic                  M1_AWVALID,
    input  logic [31:0]           M0_AWADDR,
    input  logic [31:0]           M1_AWADDR,
    input  logic [NUM_SLAVES-1:0] S_AWREADY,
    input  logic                  W_VALID,
    input  logic                  W_READY,
    input  logic                  W_LAST,
    input  logic                  B_VALID,
    input  logic                  B_READY,
    output logic                  sel_master,
    output logic [1:0]            sel_slave,
    output logic [NUM_SLAVES-1:0] S_AWEN,
    output logic                  w_en,
    output logic                  b_en,
    output logic                  dec_wready,
    output logic                  dec_bvalid,
    output logic [1:0]            dec_bresp,
    output logic                  busy
);

    logic [31:0]          m_addr  [2];
    logic [1:0]           dec_hit;
    logic [SLV_IDX_W-1:0] dec_idx [2];

    wr_state_e             state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  sel_master_q, sel_master_d;
    logic [1:0]            sel_slave_q, sel_slave_d;
    logic [NUM_SLAVES-1:0] s_awen_q, s_awen_d;
    logic                  w_en_q, w_en_d;
    logic                  b_en_q, b_en_d;
    logic                  dec_wready_q, dec_wready_d;
    logic                  dec_bvalid_q, dec_bvalid_d;
    logic [1:0]            dec_bresp_q, dec_bresp_d;
    logic                  busy_q, busy_d;
    logic                  grant;

    assign m_addr[0] = M0_AWADDR;
    assign m_addr[1] = M1_AWADDR;

    // One address decoder per master so the grant can pick a ready result.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            wr_addr_decoder #(
                .SLV_BASE  (SLV_BASE),
                .SLV_LIMIT (SLV_LIMIT)
            ) u_dec (
                .addr  (m_addr[gi]),
                .hit   (dec_hit[gi]),
                .index (dec_idx[gi])
            );
        end
    endgenerate

    // Next-state, grant and registered-output decode.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_master_d = sel_master_q;
        sel_slave_d  = sel_slave_q;
        // Lone requester wins; on a tie the master that did not go last wins.
        grant        = (M0_AWVALID && M1_AWVALID) ? ~last_grant_q : M1_AWVALID;

        case (state_q)
            ST_IDLE: begin
                if (M0_AWVALID || M1_AWVALID) begin
                    sel_master_d = grant;
                    sel_slave_d  = dec_idx[grant];
                    state_d      = dec_hit[grant] ? ST_ADDR : ST_ERR_DATA;
                end
            end
            ST_ADDR: begin
                if (S_AWREADY[sel_slave_q]) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (W_VALID && W_READY && W_LAST) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (B_VALID && B_READY) begin
                    state_d      = ST_IDLE;
                    last_grant_d = sel_master_q;
                end
            end
            ST_ERR_DATA: begin
                if (W_VALID && W_LAST) begin
                    state_d = ST_ERR_RESP;
                end
            end
            ST_ERR_RESP: begin
                if (B_READY) begin
                    state_d      = ST_IDLE;
                    last_grant_d = sel_master_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are a pure function of the next state so they line up
        // exactly with the state register after the edge.
        s_awen_d     = (state_d == ST_ADDR) ? slave_onehot(sel_slave_d) : '0;
        w_en_d       = (state_d == ST_DATA);
        b_en_d       = (state_d == ST_RESP);
        dec_wready_d = (state_d == ST_ERR_DATA);
        dec_bvalid_d = (state_d == ST_ERR_RESP);
        dec_bresp_d  = (state_d == ST_ERR_RESP) ? RESP_DECERR : RESP_OKAY;
        busy_d       = (state_d != ST_IDLE);
    end

    // State and output registers; reset parks in IDLE with M0 favoured.
    always_ff @(posedge clkk) begin
        if (resett) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            sel_master_q <= 1'b0;
            sel_slave_q  <= 2'b00;
            s_awen_q     <= '0;
            w_en_q       <= 1'b0;
            b_en_q       <= 1'b0;
            dec_wready_q <= 1'b0;
            dec_bvalid_q <= 1'b0;
            dec_bresp_q  <= RESP_OKAY;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_master_q <= sel_master_d;
            sel_slave_q  <= sel_slave_d;
            s_awen_q     <= s_awen_d;
            w_en_q       <= w_en_d;
            b_en_q       <= b_en_d;
            dec_wready_q <= dec_wready_d;
            dec_bvalid_q <= dec_bvalid_d;
            dec_bresp_q  <= dec_bresp_d;
            busy_q       <= busy_d;
        end
    end

    assign sel_master = sel_master_q;
    assign sel_slave  = sel_slave_q;
    assign S_AWEN     = s_awen_q;
    assign w_en       = w_en_q;
    assign b_en       = b_en_q;
    assign dec_wready = dec_wready_q;
    assign dec_bvalid = dec_bvalid_q;
    assign dec_bresp  = dec_bresp_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_write_arbiter_ctrl.sv
// Directed self-checking bench for write_arbiter_ctrl.
module tb_write_arbiter_ctrl;

    logic        clkk = 1'b0;
    logic        resett;
    logic        M0_AWVALID, M1_AWVALID;
    logic [31:0] M0_AWADDR, M1_AWADDR;
    logic [3:0]  S_AWREADY;
    logic        W_VALID, W_READY, W_LAST;
    logic        B_VALID, B_READY;
    logic        sel_master;
    logic [1:0]  sel_slave;
    logic [3:0]  S_AWEN;
    logic        w_en, b_en, dec_wready, dec_bvalid;
    logic [1:0]  dec_bresp;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    write_arbiter_ctrl dut (
        .clkk       (clkk),
        .resett     (resett),
        .M0_AWVALID (M0_AWVALID),
        .M1_AWVALID (M1_AWVALID),
        .M0_AWADDR  (M0_AWADDR),
        .M1_AWADDR  (M1_AWADDR),
        .S_AWREADY  (S_AWREADY),
        .W_VALID    (W_VALID),
        .W_READY    (W_READY),
        .W_LAST     (W_LAST),
        .B_VALID    (B_VALID),
        .B_READY    (B_READY),
        .sel_master (sel_master),
        .sel_slave  (sel_slave),
        .S_AWEN     (S_AWEN),
        .w_en       (w_en),
        .b_en       (b_en),
        .dec_wready (dec_wready),
        .dec_bvalid (dec_bvalid),
        .dec_bresp  (dec_bresp),
        .busy       (busy)
    );

    always #5 clkk = ~clkk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clkk);
        #1;
    endtask

    task automatic clear_inputs();
        M0_AWVALID = 1'b0; M1_AWVALID = 1'b0;
        M0_AWADDR  = '0;   M1_AWADDR  = '0;
        S_AWREADY  = '0;
        W_VALID = 1'b0; W_READY = 1'b0; W_LAST = 1'b0;
        B_VALID = 1'b0; B_READY = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        resett = 1'b1;
        tick();
        resett = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        apply_reset();
        outs = {sel_master, sel_slave, S_AWEN, w_en, b_en, dec_wready, dec_bvalid, dec_bresp, busy, 2'b00};
        n_checks++;
        if (outs !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0000", outs);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_hold busy got=%b exp=0", busy);
        end
        $display("txn reset done");
    endtask

    task automatic test_slave3_burst();
        apply_reset();
        M0_AWVALID = 1'b1; M0_AWADDR = 32'h65000000;
        tick();
        M0_AWVALID = 1'b0;
        n_checks++;
        if ({sel_master, sel_slave, S_AWEN, busy} !== {1'b0, 2'd3, 4'b1000, 1'b1}) begin
            n_fail++;
            $display("FAIL s3_grant got m=%b s=%0d awen=%b busy=%b exp m=0 s=3 awen=1000 busy=1",
                     sel_master, sel_slave, S_AWEN, busy);
        end
        tick();
        n_checks++;
        if (S_AWEN !== 4'b1000 || w_en !== 1'b0) begin
            n_fail++;
            $display("FAIL s3_addr_wait got awen=%b w_en=%b exp awen=1000 w_en=0", S_AWEN, w_en);
        end
        S_AWREADY = 4'b1000;
        tick();
        S_AWREADY = 4'b0000;
        n_checks++;
        if (w_en !== 1'b1 || S_AWEN !== 4'b0000) begin
            n_fail++;
            $display("FAIL s3_data_entry got w_en=%b awen=%b exp w_en=1 awen=0000", w_en, S_AWEN);
        end
        W_VALID = 1'b1; W_READY = 1'b1;
        for (int beat = 0; beat < 4; beat++) begin
            W_LAST = (beat == 3);
            tick();
            n_checks++;
            if (beat < 3 && (w_en !== 1'b1 || b_en !== 1'b0)) begin
                n_fail++;
                $display("FAIL s3_beat%0d got w_en=%b b_en=%b exp w_en=1 b_en=0", beat, w_en, b_en);
            end else if (beat == 3 && (w_en !== 1'b0 || b_en !== 1'b1)) begin
                n_fail++;
                $display("FAIL s3_last_beat got w_en=%b b_en=%b exp w_en=0 b_en=1", w_en, b_en);
            end
        end
        W_VALID = 1'b0; W_READY = 1'b0; W_LAST = 1'b0;
        B_VALID = 1'b1; B_READY = 1'b1;
        tick();
        B_VALID = 1'b0; B_READY = 1'b0;
        n_checks++;
        if ({busy, b_en, sel_slave} !== {1'b0, 1'b0, 2'd3}) begin
            n_fail++;
            $display("FAIL s3_resp_done got busy=%b b_en=%b s=%0d exp busy=0 b_en=0 s=3", busy, b_en, sel_slave);
        end
        $display("txn M0 -> slave3 burst of 4 complete");
    endtask

    task automatic test_round_robin();
        logic       exp_m;
        logic [3:0] exp_awen;
        apply_reset();
        M0_AWVALID = 1'b1; M0_AWADDR = 32'h00001000;
        M1_AWVALID = 1'b1; M1_AWADDR = 32'h20001000;
        S_AWREADY = 4'b1111;
        W_VALID = 1'b1; W_READY = 1'b1; W_LAST = 1'b1;
        B_VALID = 1'b1; B_READY = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            exp_m    = ((t / 4) % 2) == 1;
            exp_awen = exp_m ? 4'b0010 : 4'b0001;
            n_checks++;
            case (t % 4)
                0: if (sel_master !== exp_m || S_AWEN !== exp_awen || busy !== 1'b1) begin
                       n_fail++;
                       $display("FAIL rr_grant t=%0d got m=%b awen=%b busy=%b exp m=%b awen=%b busy=1",
                                t, sel_master, S_AWEN, busy, exp_m, exp_awen);
                   end
                1: if (w_en !== 1'b1) begin
                       n_fail++;
                       $display("FAIL rr_data t=%0d got w_en=%b exp 1", t, w_en);
                   end
                2: if (b_en !== 1'b1) begin
                       n_fail++;
                       $display("FAIL rr_resp t=%0d got b_en=%b exp 1", t, b_en);
                   end
                default: if (busy !== 1'b0) begin
                       n_fail++;
                       $display("FAIL rr_bubble t=%0d got busy=%b exp 0", t, busy);
                   end
            endcase
            if (t % 4 == 0) $display("txn round-robin grant to M%0d", sel_master);
        end
        clear_inputs();
    endtask

    task automatic test_decerr();
        apply_reset();
        M1_AWVALID = 1'b1; M1_AWADDR = 32'h80000000;
        tick();
        M1_AWVALID = 1'b0;
        n_checks++;
        if ({sel_master, dec_wready, S_AWEN, w_en, busy} !== {1'b1, 1'b1, 4'b0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL err_entry got m=%b wr=%b awen=%b w_en=%b busy=%b exp m=1 wr=1 awen=0000 w_en=0 busy=1",
                     sel_master, dec_wready, S_AWEN, w_en, busy);
        end
        W_VALID = 1'b1; W_LAST = 1'b0;
        tick();
        n_checks++;
        if (dec_wready !== 1'b1 || dec_bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_beat0 got wr=%b bv=%b exp wr=1 bv=0", dec_wready, dec_bvalid);
        end
        W_LAST = 1'b1;
        tick();
        W_VALID = 1'b0; W_LAST = 1'b0;
        n_checks++;
        if ({dec_bvalid, dec_bresp, dec_wready, S_AWEN} !== {1'b1, 2'b11, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL err_resp got bv=%b bresp=%b wr=%b awen=%b exp bv=1 bresp=11 wr=0 awen=0000",
                     dec_bvalid, dec_bresp, dec_wready, S_AWEN);
        end
        tick();
        n_checks++;
        if (dec_bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL err_resp_hold got bv=%b exp 1", dec_bvalid);
        end
        B_READY = 1'b1;
        tick();
        B_READY = 1'b0;
        n_checks++;
        if ({busy, dec_bvalid, dec_bresp} !== {1'b0, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL err_done got busy=%b bv=%b bresp=%b exp busy=0 bv=0 bresp=00",
                     busy, dec_bvalid, dec_bresp);
        end
        $display("txn M1 -> unmapped, DECERR returned");
    endtask

    task automatic test_boundaries();
        logic [31:0] addrs [5];
        logic [1:0]  slv   [5];
        logic [3:0]  exp_awen;
        addrs[0] = 32'h1FFFFFFF; slv[0] = 2'd0;
        addrs[1] = 32'h20000000; slv[1] = 2'd1;
        addrs[2] = 32'h7FFFFFFF; slv[2] = 2'd3;
        addrs[3] = 32'h00000000; slv[3] = 2'd0;
        addrs[4] = 32'h5FFFFFFF; slv[4] = 2'd2;
        for (int i = 0; i < 5; i++) begin
            apply_reset();
            M0_AWVALID = 1'b1; M0_AWADDR = addrs[i];
            tick();
            M0_AWVALID = 1'b0;
            exp_awen = 4'b0001 << slv[i];
            n_checks++;
            if (sel_slave !== slv[i] || S_AWEN !== exp_awen || dec_wready !== 1'b0) begin
                n_fail++;
                $display("FAIL boundary addr=%h got s=%0d awen=%b wr=%b exp s=%0d awen=%b wr=0",
                         addrs[i], sel_slave, S_AWEN, dec_wready, slv[i], exp_awen);
            end
            $display("txn decode %h -> slave%0d", addrs[i], sel_slave);
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        // One full M0 transaction first so the tie preference points at M1.
        M0_AWVALID = 1'b1; M0_AWADDR = 32'h00000100;
        tick();
        M0_AWVALID = 1'b0;
        S_AWREADY = 4'b0001;
        tick();
        S_AWREADY = 4'b0000;
        W_VALID = 1'b1; W_READY = 1'b1; W_LAST = 1'b1;
        tick();
        W_VALID = 1'b0; W_READY = 1'b0; W_LAST = 1'b0;
        B_VALID = 1'b1; B_READY = 1'b1;
        tick();
        B_VALID = 1'b0; B_READY = 1'b0;
        tick();
        // M1 to slave2, then reset in the middle of its data phase.
        M1_AWVALID = 1'b1; M1_AWADDR = 32'h40000000;
        tick();
        M1_AWVALID = 1'b0;
        S_AWREADY = 4'b0100;
        tick();
        S_AWREADY = 4'b0000;
        n_checks++;
        if (w_en !== 1'b1 || sel_master !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_data got w_en=%b m=%b exp w_en=1 m=1", w_en, sel_master);
        end
        W_VALID = 1'b1; W_READY = 1'b1; W_LAST = 1'b0;
        tick();
        resett = 1'b1;
        tick();
        resett = 1'b0;
        clear_inputs();
        n_checks++;
        if ({sel_master, sel_slave, S_AWEN, w_en, b_en, dec_wready, dec_bvalid, dec_bresp, busy} !== 14'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got m=%b s=%0d awen=%b w=%b b=%b busy=%b exp all 0",
                     sel_master, sel_slave, S_AWEN, w_en, b_en, busy);
        end
        M0_AWVALID = 1'b1; M0_AWADDR = 32'h00000200;
        M1_AWVALID = 1'b1; M1_AWADDR = 32'h20000200;
        tick();
        clear_inputs();
        n_checks++;
        if (sel_master !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_tie got m=%b busy=%b exp m=0 busy=1", sel_master, busy);
        end
        $display("txn reset mid-burst, tie then granted to M%0d", sel_master);
    endtask

    task automatic test_wrong_awready();
        apply_reset();
        M0_AWVALID = 1'b1; M0_AWADDR = 32'h40000010;
        tick();
        M0_AWVALID = 1'b0;
        S_AWREADY = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (S_AWEN !== 4'b0100 || w_en !== 1'b0) begin
                n_fail++;
                $display("FAIL wrong_ready%0d got awen=%b w_en=%b exp awen=0100 w_en=0", i, S_AWEN, w_en);
            end
        end
        S_AWREADY = 4'b0100;
        tick();
        S_AWREADY = 4'b0000;
        n_checks++;
        if (w_en !== 1'b1 || S_AWEN !== 4'b0000) begin
            n_fail++;
            $display("FAIL right_ready got w_en=%b awen=%b exp w_en=1 awen=0000", w_en, S_AWEN);
        end
        $display("txn slave2 AW accepted only on its own ready");
    endtask

    initial begin
        resett = 1'b1;
        clear_inputs();
        test_reset();
        test_slave3_burst();
        test_round_robin();
        test_decerr();
        test_boundaries();
        test_reset_mid_burst();
        test_wrong_awready();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
